// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle MUL/DIV sequencer driving the shared 16-bit ALU one micro-op per cycle.
// DIV support is built only when ALU_SEQ_DIV_EN is defined; otherwise cmd=1 takes the error path.
module alu_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter bit MUL_EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [3:0]       alu_shift_d,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [3:0]       alu_szcv
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b1000;
    typedef enum logic [2:0] {
        IDLE, MUL_ADD, MUL_SHL, DONE
`ifdef ALU_SEQ_DIV_EN
        , DIV_SHL, DIV_SUB
`endif
    } state_t;
    state_t state;
    logic [WIDTH-1:0] acc, mc, mp;
    logic [4:0] iter;
    logic bad, last;
    assign last = iter == 5'(WIDTH - 1);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_SUB = 4'b0001;
    logic [WIDTH-1:0] quo, r_sub, q_sub, r_shl;
    logic ge, unused;
    // b-a cannot overflow with 14-bit operands, so S==V means remainder >= divisor
    assign ge = alu_szcv[3] == alu_szcv[0];
    assign r_sub = ge ? alu_res : acc;
    assign q_sub = {quo[WIDTH-2:0], ge};
    assign r_shl = alu_res | {{(WIDTH-1){1'b0}}, mc[WIDTH-1]};
    assign bad = cmd[1] || (cmd[0] && (opa[WIDTH-1:WIDTH-2] != 2'b0 ||
                 opb[WIDTH-1:WIDTH-2] != 2'b0 || opb == '0));
    assign unused = ^alu_szcv[2:1];
`else
    logic unused;
    assign bad = cmd != 2'd0;
    assign unused = ^alu_szcv;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            {busy, done, err, alu_own} <= '0;
            result_lo <= '0;
            result_hi <= '0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            alu_shift_d <= '0;
            acc <= '0;
            mc <= '0;
            mp <= '0;
            iter <= '0;
`ifdef ALU_SEQ_DIV_EN
            quo <= '0;
`endif
        end else begin
            done <= 1'b0;
            alu_own <= 1'b0;
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= OP_ADD;
            alu_shift_d <= '0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    err <= bad;
                    iter <= '0;
                    acc <= '0;
                    mc <= opa;
                    mp <= opb;
`ifdef ALU_SEQ_DIV_EN
                    quo <= '0;
`endif
                    if (bad) begin
                        state <= DONE;
                        done <= 1'b1;
                        result_lo <= '1;
                        result_hi <= opa;
                    end
`ifdef ALU_SEQ_DIV_EN
                    else if (cmd[0]) begin
                        state <= DIV_SHL;
                        alu_own <= 1'b1;
                        alu_op <= OP_SLL;
                        alu_shift_d <= 4'd1;
                    end
`endif
                    else begin
                        state <= MUL_ADD;
                        alu_own <= 1'b1;
                        alu_a <= opa;
                    end
                end
                MUL_ADD: begin
                    if (mp[0]) acc <= alu_res;
                    state <= MUL_SHL;
                    alu_own <= 1'b1;
                    alu_b <= mc;
                    alu_op <= OP_SLL;
                    alu_shift_d <= 4'd1;
                end
                MUL_SHL: begin
                    mc <= alu_res;
                    mp <= mp >> 1;
                    iter <= iter + 5'd1;
                    if (last || (MUL_EARLY_EXIT && mp[WIDTH-1:1] == '0)) begin
                        state <= DONE;
                        done <= 1'b1;
                        result_lo <= acc;
                        result_hi <= '0;
                    end else begin
                        state <= MUL_ADD;
                        alu_own <= 1'b1;
                        alu_a <= alu_res;
                        alu_b <= acc;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                DIV_SHL: begin
                    acc <= r_shl;
                    mc <= mc << 1;
                    state <= DIV_SUB;
                    alu_own <= 1'b1;
                    alu_a <= mp;
                    alu_b <= r_shl;
                    alu_op <= OP_SUB;
                end
                DIV_SUB: begin
                    acc <= r_sub;
                    quo <= q_sub;
                    iter <= iter + 5'd1;
                    if (last) begin
                        state <= DONE;
                        done <= 1'b1;
                        result_lo <= q_sub;
                        result_hi <= r_sub;
                    end else begin
                        state <= DIV_SHL;
                        alu_own <= 1'b1;
                        alu_b <= r_sub;
                        alu_op <= OP_SLL;
                        alu_shift_d <= 4'd1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
